// File: rtl/arc4_seq_if.sv
// arc4_seq_if: top-level start/ready handshake of the ARC4 phase sequencer.
// The master issues en and observes rdy/phase/err; the sequencer is the slave.
interface arc4_seq_if;
    logic       en;
    logic       rdy;
    logic [1:0] phase;
    logic       err;

    modport master (
        output en,
        input  rdy,
        input  phase,
        input  err
    );

    modport slave (
        input  en,
        output rdy,
        output phase,
        output err
    );
endinterface

// File: rtl/arc4_seq.sv
// arc4_seq: runs init -> ksa -> prga once per start and muxes the shared S port.
// Optional phase watchdog is built when ARC4_WATCHDOG_EN is defined.
module arc4_seq #(
    parameter int WDOG_CYCLES = 4095
) (
    input  logic       clk,
    input  logic       rst_n,
    arc4_seq_if.slave  bus,
    output logic       init_en,
    output logic       ksa_en,
    output logic       prga_en,
    input  logic       init_rdy,
    input  logic       ksa_rdy,
    input  logic       prga_rdy,
    input  logic [7:0] init_addr,
    input  logic [7:0] ksa_addr,
    input  logic [7:0] prga_addr,
    input  logic [7:0] init_wrdata,
    input  logic [7:0] ksa_wrdata,
    input  logic [7:0] prga_wrdata,
    input  logic       init_wren,
    input  logic       ksa_wren,
    input  logic       prga_wren,
    output logic [7:0] s_addr,
    output logic [7:0] s_wrdata,
    output logic       s_wren
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_INIT_GO,
        S_INIT_BUSY,
        S_INIT_DONE,
        S_KSA_GO,
        S_KSA_BUSY,
        S_KSA_DONE,
        S_PRGA_GO,
        S_PRGA_BUSY,
        S_PRGA_DONE,
        S_ERR
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [1:0] w_phase;
    logic       w_go_nxt;

    assign w_go_nxt = (w_state_nxt == S_INIT_GO) ||
                      (w_state_nxt == S_KSA_GO)  ||
                      (w_state_nxt == S_PRGA_GO);

`ifdef ARC4_WATCHDOG_EN
    localparam int CNT_W = $clog2(WDOG_CYCLES + 1);
    localparam logic [CNT_W-1:0] WDOG_MAX = CNT_W'(WDOG_CYCLES);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_inc;
    logic             w_wdog_live;

    assign w_cnt_inc   = r_cnt + 1'b1;
    assign w_wdog_live = (r_state == S_INIT_BUSY) ||
                         (r_state == S_INIT_DONE) ||
                         (r_state == S_KSA_BUSY)  ||
                         (r_state == S_KSA_DONE)  ||
                         (r_state == S_PRGA_BUSY) ||
                         (r_state == S_PRGA_DONE);

    // Cycles spent waiting on the current sub-block; restarts at each GO.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (w_go_nxt) begin
            r_cnt <= '0;
        end else if (w_wdog_live) begin
            r_cnt <= w_cnt_inc;
        end
    end
`else
    logic w_unused_go;
    assign w_unused_go = w_go_nxt;
`endif

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state: GO is one cycle, BUSY waits for rdy low, DONE for rdy high.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE:      if (bus.en)    w_state_nxt = S_INIT_GO;
            S_INIT_GO:                  w_state_nxt = S_INIT_BUSY;
            S_INIT_BUSY: if (!init_rdy) w_state_nxt = S_INIT_DONE;
            S_INIT_DONE: if (init_rdy)  w_state_nxt = S_KSA_GO;
            S_KSA_GO:                   w_state_nxt = S_KSA_BUSY;
            S_KSA_BUSY:  if (!ksa_rdy)  w_state_nxt = S_KSA_DONE;
            S_KSA_DONE:  if (ksa_rdy)   w_state_nxt = S_PRGA_GO;
            S_PRGA_GO:                  w_state_nxt = S_PRGA_BUSY;
            S_PRGA_BUSY: if (!prga_rdy) w_state_nxt = S_PRGA_DONE;
            S_PRGA_DONE: if (prga_rdy)  w_state_nxt = S_IDLE;
            S_ERR:                      w_state_nxt = S_ERR;
            default:                    w_state_nxt = S_IDLE;
        endcase
`ifdef ARC4_WATCHDOG_EN
        if (w_wdog_live && (w_state_nxt == r_state) &&
            (w_cnt_inc >= WDOG_MAX)) begin
            w_state_nxt = S_ERR;
        end
`endif
    end

    // Moore outputs decoded from the current state.
    always_comb begin
        w_phase = 2'd0;
        bus.rdy = 1'b0;
        bus.err = 1'b0;
        init_en = 1'b0;
        ksa_en  = 1'b0;
        prga_en = 1'b0;
        unique case (r_state)
            S_IDLE:      bus.rdy = 1'b1;
            S_INIT_GO:   begin w_phase = 2'd1; init_en = 1'b1; end
            S_INIT_BUSY: w_phase = 2'd1;
            S_INIT_DONE: w_phase = 2'd1;
            S_KSA_GO:    begin w_phase = 2'd2; ksa_en = 1'b1; end
            S_KSA_BUSY:  w_phase = 2'd2;
            S_KSA_DONE:  w_phase = 2'd2;
            S_PRGA_GO:   begin w_phase = 2'd3; prga_en = 1'b1; end
            S_PRGA_BUSY: w_phase = 2'd3;
            S_PRGA_DONE: w_phase = 2'd3;
`ifdef ARC4_WATCHDOG_EN
            S_ERR:       bus.err = 1'b1;
`else
            S_ERR:       bus.err = 1'b0;
`endif
            default:     w_phase = 2'd0;
        endcase
    end

    assign bus.phase = w_phase;

    // Shared S port: only the active phase's sub-block reaches memory.
    always_comb begin
        s_addr   = 8'd0;
        s_wrdata = 8'd0;
        s_wren   = 1'b0;
        unique case (w_phase)
            2'd1: begin
                s_addr   = init_addr;
                s_wrdata = init_wrdata;
                s_wren   = init_wren;
            end
            2'd2: begin
                s_addr   = ksa_addr;
                s_wrdata = ksa_wrdata;
                s_wren   = ksa_wren;
            end
            2'd3: begin
                s_addr   = prga_addr;
                s_wrdata = prga_wrdata;
                s_wren   = prga_wren;
            end
            default: begin
                s_addr   = 8'd0;
                s_wrdata = 8'd0;
                s_wren   = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_arc4_seq.sv
// tb_arc4_seq: directed/randomized bench for the ARC4 phase sequencer.
// Stub sub-blocks with programmable busy time; phase timeline model per run.
module tb_arc4_seq;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    arc4_seq_if bus();

    logic       init_en, ksa_en, prga_en;
    logic       init_rdy, ksa_rdy, prga_rdy;
    logic [7:0] init_addr, ksa_addr, prga_addr;
    logic [7:0] init_wrdata, ksa_wrdata, prga_wrdata;
    logic       init_wren, ksa_wren, prga_wren;
    logic [7:0] s_addr, s_wrdata;
    logic       s_wren;

    arc4_seq #(.WDOG_CYCLES(15)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus),
        .init_en(init_en), .ksa_en(ksa_en), .prga_en(prga_en),
        .init_rdy(init_rdy), .ksa_rdy(ksa_rdy), .prga_rdy(prga_rdy),
        .init_addr(init_addr), .ksa_addr(ksa_addr), .prga_addr(prga_addr),
        .init_wrdata(init_wrdata), .ksa_wrdata(ksa_wrdata),
        .prga_wrdata(prga_wrdata),
        .init_wren(init_wren), .ksa_wren(ksa_wren), .prga_wren(prga_wren),
        .s_addr(s_addr), .s_wrdata(s_wrdata), .s_wren(s_wren)
    );

    int tests = 0;
    int fails = 0;
    int n_init = 3, n_ksa = 5, n_prga = 7;
    bit ksa_hang = 1'b0;
    int c_init = 0, c_ksa = 0, c_prga = 0;
    int mux_bad = 0;
    logic [7:0] mem [256];

    // Stub sub-blocks: rdy drops after en, stays low n cycles.
    always @(posedge clk) begin
        if (!rst_n) begin
            init_rdy <= 1'b1; c_init <= 0;
            ksa_rdy  <= 1'b1; c_ksa  <= 0;
            prga_rdy <= 1'b1; c_prga <= 0;
        end else begin
            if (init_en) begin
                init_rdy <= 1'b0; c_init <= 0;
            end else if (!init_rdy) begin
                if (c_init >= n_init - 1) init_rdy <= 1'b1;
                c_init <= c_init + 1;
            end
            if (ksa_en) begin
                ksa_rdy <= 1'b0; c_ksa <= 0;
            end else if (!ksa_rdy) begin
                if (c_ksa >= n_ksa - 1 && !ksa_hang) ksa_rdy <= 1'b1;
                c_ksa <= c_ksa + 1;
            end
            if (prga_en) begin
                prga_rdy <= 1'b0; c_prga <= 0;
            end else if (!prga_rdy) begin
                if (c_prga >= n_prga - 1) prga_rdy <= 1'b1;
                c_prga <= c_prga + 1;
            end
        end
    end

    assign init_addr   = c_init[7:0];
    assign init_wrdata = c_init[7:0];
    assign init_wren   = !init_rdy;
    assign ksa_addr    = 8'h40 + c_ksa[7:0];
    assign ksa_wrdata  = 8'hEE;
    assign ksa_wren    = 1'b1;
    assign prga_addr   = 8'h80 + c_prga[7:0];
    assign prga_wrdata = 8'hDD;
    assign prga_wren   = 1'b1;

    // S memory behind the muxed port.
    always @(posedge clk) begin
        if (s_wren === 1'b1) mem[s_addr] <= s_wrdata;
    end

    // Port-selection rule: active phase's sub-block, else all zero.
    always @(negedge clk) begin
        logic [16:0] e;
        if (rst_n && !$isunknown(bus.phase)) begin
            case (bus.phase)
                2'd1:    e = {init_addr, init_wrdata, init_wren};
                2'd2:    e = {ksa_addr, ksa_wrdata, ksa_wren};
                2'd3:    e = {prga_addr, prga_wrdata, prga_wren};
                default: e = 17'd0;
            endcase
            if ({s_addr, s_wrdata, s_wren} !== e) mux_bad <= mux_bad + 1;
        end
    end

    function automatic logic [6:0] obs_vec();
        return {bus.phase, init_en, ksa_en, prga_en, bus.rdy, bus.err};
    endfunction

    localparam logic [6:0] IDLE_V = 7'b00_000_10;

    task automatic check_run(input int a, input int b, input int c,
                             input bit drop_en, input bit noise,
                             input bit chk_mem);
        int total;
        int ph;
        bit fst;
        logic [6:0] exp_v;
        logic [6:0] o;
        total = a + b + c + 6;
        for (int k = 0; k < total; k++) begin
            if (k < a + 2) ph = 1;
            else if (k < a + b + 4) ph = 2;
            else ph = 3;
            fst = (k == 0) || (k == a + 2) || (k == a + b + 4);
            exp_v = {2'(ph), fst && ph == 1, fst && ph == 2,
                     fst && ph == 3, 1'b0, 1'b0};
            o = obs_vec();
            tests++;
            assert (o === exp_v) else begin
                fails++;
                $error("FAIL run k=%0d obs=%b exp=%b", k, o, exp_v);
            end
            if (chk_mem && k == a + 2) begin
                int bad;
                bad = 0;
                for (int i = 0; i < 256; i++)
                    if (mem[i] !== 8'(i)) bad++;
                tests++;
                assert (bad === 0) else begin
                    fails++;
                    $error("FAIL smem bad_entries=%0d exp=0", bad);
                end
            end
            if (drop_en && k == 0) bus.en = 1'b0;
            if (noise && k > 0) bus.en = 1'($urandom_range(0, 1));
            if (noise && k == total - 1) bus.en = 1'b0;
            @(negedge clk);
        end
        o = obs_vec();
        tests++;
        assert (o === IDLE_V) else begin
            fails++;
            $error("FAIL run_end obs=%b exp=%b", o, IDLE_V);
        end
    endtask

    task automatic start_run(input int a, input int b, input int c,
                             input bit noise, input bit chk_mem);
        n_init = a; n_ksa = b; n_prga = c;
        bus.en = 1'b1;
        @(negedge clk);
        check_run(a, b, c, 1'b1, noise, chk_mem);
        @(negedge clk);
    endtask

    initial begin
        logic [6:0] o;
        int a, b, c;
        bit seen;
        for (int i = 0; i < 256; i++) mem[i] = 8'hFF;
        bus.en = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 5; i++) begin
            o = obs_vec();
            tests++;
            assert ({o, s_wren} === {IDLE_V, 1'b0}) else begin
                fails++;
                $error("FAIL idle%0d obs=%b wren=%b exp=%b wren=0",
                       i, o, s_wren, IDLE_V);
            end
            @(negedge clk);
        end

        start_run(3, 5, 7, 1'b0, 1'b0);

        start_run(256, $urandom_range(1, 10), $urandom_range(1, 10),
                  1'b0, 1'b1);

        for (int r = 0; r < 4; r++) begin
            start_run($urandom_range(1, 12), $urandom_range(1, 12),
                      $urandom_range(1, 12), 1'b1, 1'b0);
        end

        a = $urandom_range(1, 6); b = $urandom_range(1, 6);
        c = $urandom_range(1, 6);
        n_init = a; n_ksa = b; n_prga = c;
        bus.en = 1'b1;
        @(negedge clk);
        check_run(a, b, c, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check_run(a, b, c, 1'b1, 1'b0, 1'b0);
        @(negedge clk);

        n_init = 3; n_ksa = 6; n_prga = 4;
        bus.en = 1'b1;
        @(negedge clk);
        bus.en = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            if (bus.phase === 2'd2) seen = 1'b1;
            else @(negedge clk);
        end
        tests++;
        assert (seen === 1'b1) else begin
            fails++;
            $error("FAIL reach_ksa phase=%0d exp=2", bus.phase);
        end
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        o = obs_vec();
        tests++;
        assert ({o, s_wren} === {IDLE_V, 1'b0}) else begin
            fails++;
            $error("FAIL mid_reset obs=%b wren=%b exp=%b wren=0",
                   o, s_wren, IDLE_V);
        end
        rst_n = 1'b1;
        start_run(2, 4, 3, 1'b0, 1'b0);

        n_init = 3; n_ksa = 5; ksa_hang = 1'b1;
        bus.en = 1'b1;
        @(negedge clk);
        bus.en = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            if (ksa_en === 1'b1) seen = 1'b1;
            else @(negedge clk);
        end
        tests++;
        assert (seen === 1'b1) else begin
            fails++;
            $error("FAIL ksa_en_seen got=%b exp=1", seen);
        end
`ifdef ARC4_WATCHDOG_EN
        seen = 1'b0;
        for (int i = 0; i < 16 && !seen; i++) begin
            @(negedge clk);
            if (bus.err === 1'b1) seen = 1'b1;
        end
        tests++;
        assert (seen === 1'b1) else begin
            fails++;
            $error("FAIL wdog_err got=%b exp=1", bus.err);
        end
        bus.en = 1'b1;
        repeat (5) @(negedge clk);
        bus.en = 1'b0;
        o = obs_vec();
        tests++;
        assert ({o, s_wren} === {7'b00_000_01, 1'b0}) else begin
            fails++;
            $error("FAIL err_sticky obs=%b wren=%b exp=0000001 wren=0",
                   o, s_wren);
        end
`else
        repeat (40) @(negedge clk);
        bus.en = 1'b1;
        repeat (3) @(negedge clk);
        bus.en = 1'b0;
        o = obs_vec();
        tests++;
        assert (o === 7'b10_000_00) else begin
            fails++;
            $error("FAIL hang_ksa obs=%b exp=1000000", o);
        end
`endif
        rst_n = 1'b0;
        ksa_hang = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        o = obs_vec();
        tests++;
        assert (o === IDLE_V) else begin
            fails++;
            $error("FAIL post_reset obs=%b exp=%b", o, IDLE_V);
        end

        tests++;
        assert (mux_bad === 0) else begin
            fails++;
            $error("FAIL s_port_mux bad_cycles=%0d exp=0", mux_bad);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
